// File: rtl/rv_control_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath: decodes the held instruction,
// drives all datapath controls and strobes pc_en once per retired instruction.
module rv_control_fsm #(
  parameter int W  = 32,
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic [W-1:0]  instruction_i,
  input  logic          zero_i,
  output logic          branch_o,
  output logic          branch_confirm_o,
  output logic          is_lui_o,
  output logic          is_jal_o,
  output logic          is_jalr_o,
  output logic          mem2reg_o,
  output logic          memwrite_o,
  output logic          alusrc_o,
  output logic          regwrite_o,
  output logic [3:0]    aluctl_o,
  output logic          pc_en_o,
  output logic          halted_o,
  output logic [1:0]    halt_cause_o,
  output logic [CW-1:0] retired_o
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_e        state_q, state_d;
  logic [1:0]    halt_cause_q, halt_cause_d;
  logic [CW-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] f3_alu;
  logic       f3_ok;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];

  // ALU op shared by R-type and I-ALU; f3_ok flags the four supported funct3 values.
  always_comb begin
    f3_alu = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b111:  f3_alu = 4'b0000;
      3'b110:  f3_alu = 4'b0001;
      3'b010:  f3_alu = 4'b0111;
      default: f3_ok  = 1'b0;
    endcase
  end

  logic       dec_legal, dec_load, dec_ecall;
  logic       dec_branch, dec_bconf, dec_lui, dec_jal, dec_jalr;
  logic       dec_mem2reg, dec_memwrite, dec_alusrc, dec_regwrite;
  logic [3:0] dec_aluctl;

  always_comb begin
    dec_legal    = 1'b0;
    dec_load     = 1'b0;
    dec_ecall    = (instruction_i == W'(32'h0000_0073));
    dec_branch   = 1'b0;
    dec_bconf    = 1'b0;
    dec_lui      = 1'b0;
    dec_jal      = 1'b0;
    dec_jalr     = 1'b0;
    dec_mem2reg  = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_aluctl   = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        dec_regwrite = 1'b1;
        if (funct7 == 7'b0000000 && f3_ok) begin
          dec_legal  = 1'b1;
          dec_aluctl = f3_alu;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal  = 1'b1;
          dec_aluctl = ALU_SUB;
        end
      end
      7'b0010011: begin
        dec_legal    = f3_ok;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluctl   = f3_alu;
      end
      7'b0000011: begin
        dec_legal   = (funct3 == 3'b010);
        dec_load    = 1'b1;
        dec_alusrc  = 1'b1;
        dec_mem2reg = 1'b1;
      end
      7'b0100011: begin
        dec_legal    = (funct3 == 3'b010);
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      7'b1100011: begin
        dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_branch = 1'b1;
        dec_aluctl = ALU_SUB;
        dec_bconf  = funct3[0] ? ~zero_i : zero_i;
      end
      7'b1101111: begin
        dec_legal    = 1'b1;
        dec_jal      = 1'b1;
        dec_regwrite = 1'b1;
      end
      7'b1100111: begin
        dec_legal    = (funct3 == 3'b000);
        dec_jalr     = 1'b1;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      7'b0110111: begin
        dec_legal    = 1'b1;
        dec_lui      = 1'b1;
        dec_regwrite = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Outputs depend only on state (plus the decode in EXEC), so an asynchronous
  // reset drops every strobe in the same instant.
  always_comb begin
    state_d          = state_q;
    halt_cause_d     = halt_cause_q;
    branch_o         = 1'b0;
    branch_confirm_o = 1'b0;
    is_lui_o         = 1'b0;
    is_jal_o         = 1'b0;
    is_jalr_o        = 1'b0;
    mem2reg_o        = 1'b0;
    memwrite_o       = 1'b0;
    alusrc_o         = 1'b0;
    regwrite_o       = 1'b0;
    aluctl_o         = ALU_ADD;
    pc_en_o          = 1'b0;
    case (state_q)
      S_FETCH: if (run_i) state_d = S_EXEC;
      S_EXEC: begin
        if (dec_legal) begin
          branch_o         = dec_branch;
          branch_confirm_o = dec_bconf;
          is_lui_o         = dec_lui;
          is_jal_o         = dec_jal;
          is_jalr_o        = dec_jalr;
          mem2reg_o        = dec_mem2reg;
          memwrite_o       = dec_memwrite;
          alusrc_o         = dec_alusrc;
          regwrite_o       = dec_regwrite & ~dec_load;
          aluctl_o         = dec_aluctl;
          pc_en_o          = ~dec_load;
          state_d          = dec_load ? S_WB : S_FETCH;
        end else begin
          state_d      = S_HALT;
          halt_cause_d = dec_ecall ? 2'b01 : 2'b10;
        end
      end
      S_WB: begin
        mem2reg_o  = 1'b1;
        alusrc_o   = 1'b1;
        regwrite_o = 1'b1;
        pc_en_o    = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign retired_d    = retired_q + {{(CW-1){1'b0}}, pc_en_o};
  assign halted_o     = (state_q == S_HALT);
  assign halt_cause_o = halt_cause_q;
  assign retired_o    = retired_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      halt_cause_q <= 2'b00;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
      retired_q    <= retired_d;
    end
  end

endmodule

// File: doc/rv_control_fsm.md
# rv_control_fsm

Multi-cycle control sequencer for the RV32I datapath. It decodes the current instruction and drives every datapath control input. It also gates the PC update through `pc_en`, so each instruction retires exactly once. Loads take an extra cycle to absorb the synchronous read latency of the data memory. The block sits beside `datapath`: it consumes `instruction` and `zero`, and supplies all of its control inputs.

## Interface
- `W`, 32, instruction width
- `CW`, 32, width of the retired-instruction counter

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  permit issue of the next instruction; sampled only in FETCH
- `instruction`  in  W  current instruction from the datapath
- `zero`  in  1  ALU zero flag from the datapath
- `branch`, `branch_confirm`, `is_lui`, `is_jal`, `is_jalr`, `mem2reg`, `memwrite`, `alusrc`, `regwrite`  out  1 each  datapath controls
- `aluctl`  out  4  ALU operation
- `pc_en`  out  1  single-cycle PC update strobe; the datapath PC register loads only when it is high
- `halted`  out  1  FSM is in HALT
- `halt_cause`  out  2  00 none, 01 ecall, 10 illegal instruction
- `retired`  out  CW  count of retired instructions; wraps modulo 2^CW

## Operation
- States: FETCH, EXEC, WB, HALT.
- FETCH: all controls are 0.
  - `run`=1 → EXEC.
  - `run`=0 → stay in FETCH.
- EXEC: controls are decoded from `instruction` (opcode [6:0], funct3 [14:12], funct7 [31:25]).
  - R-type 0110011:
    - funct7=0000000: funct3 000 ADD 0010, 111 AND 0000, 110 OR 0001, 010 SLT 0111.
    - funct7=0100000 with funct3 000: SUB 0110.
    - Controls: regwrite=1, alusrc=0.
  - I-ALU 0010011: funct3 000 ADDI, 111 ANDI, 110 ORI, 010 SLTI. Controls: alusrc=1, regwrite=1.
  - Load 0000011, funct3 010: alusrc=1, aluctl=0010, mem2reg=1, regwrite=0, pc_en=0. Next state WB.
  - Store 0100011, funct3 010: alusrc=1, aluctl=0010, memwrite=1.
  - Branch 1100011, funct3 000 (BEQ) or 001 (BNE):
    - alusrc=0, aluctl=0110, branch=1.
    - branch_confirm = `zero` for BEQ, `~zero` for BNE (combinational).
  - JAL 1101111: is_jal=1, regwrite=1.
  - JALR 1100111, funct3 000: is_jalr=1, alusrc=1, aluctl=0010, regwrite=1.
  - LUI 0110111: is_lui=1, regwrite=1.
  - Every non-load legal instruction: pc_en=1 and `retired` increments at the edge; next state FETCH.
  - ECALL (exactly 0x00000073): no writes, pc_en=0; next state HALT with cause 01.
  - Anything else is illegal: opcode, funct3 or funct7 outside the lists above. No writes, pc_en=0; next state HALT with cause 10.
- WB (loads only): mem2reg=1, alusrc=1, aluctl=0010, regwrite=1, pc_en=1. `retired` increments; next state FETCH.
- HALT:
  - All controls are 0; `halted`=1; `halt_cause` holds its value.
  - Only reset leaves HALT.
- Defaults for any output not listed in a state: 0. aluctl defaults to 0010.

## Timing
- Reset (rst=0): state=FETCH, `retired`=0, `halt_cause`=00, `halted`=0, all controls 0, aluctl=0010.
  - Takes effect immediately and asynchronously.
  - Control outputs are decoded from state, so they fall in the same instant.
- First FETCH after reset release with `run`=1: EXEC on the next edge.
- Instructions per cycle:
  - Non-load: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles (FETCH, EXEC, WB).
  - ECALL/illegal: 2 cycles to HALT.
- `instruction` must stay stable from FETCH through EXEC/WB; this holds because PC changes only on the `pc_en` edge.
- `run` dropping during EXEC or WB does not abort the instruction; it only stalls the next FETCH.
- `pc_en`, `regwrite` and `memwrite` are each high for exactly one cycle per instruction, and never in FETCH or HALT.
- Counter wrap: `retired` = 2^CW−1 plus one retirement → 0; no flag is raised.
- Reset during EXEC or WB: a write strobe active in that cycle is cancelled; the instruction does not retire.

## Test plan
- Reset, run=1, `instruction`=0x00500093 (addi x1,x0,5):
  - FETCH: all controls 0.
  - EXEC: regwrite=1, alusrc=1, aluctl=0010, pc_en=1.
  - `retired`=1 after 2 edges.
- 0x402081B3 (sub x3,x1,x2) → EXEC aluctl=0110, alusrc=0, regwrite=1.
- 0x0020A233 (slt x4,x1,x2) → EXEC aluctl=0111, regwrite=1.
- 0x00002283 (lw x5,0(x0)):
  - EXEC: mem2reg=1, regwrite=0, pc_en=0.
  - WB: mem2reg=1, regwrite=1, pc_en=1.
  - `retired` increments after 3 edges.
- 0x00000463 (beq) with zero=1 → branch=1, branch_confirm=1.
- 0x00001463 (bne) with zero=1 → branch=1, branch_confirm=0, pc_en=1.
- 0xFFFFFFFF → HALT after EXEC: halted=1, halt_cause=10, pc_en stays 0 for 10 further cycles.
- 0x00000073 → halt_cause=01.
- Hold run=0 in FETCH for 5 cycles → no state change, `retired` unchanged.
- Drive rst=0 mid-EXEC of addi → regwrite and pc_en fall immediately, `retired`=0.
